knn_query_sequencer: RTL

KNN_QUERY_SEQUENCER -- requirements
Module: knn_query_sequencer

---
 rtl/knn_pkg.sv | 12 +
 rtl/knn_query_fifo.sv | 40 ++++
 rtl/knn_query_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: widths, sequencer states and the query record shared by the
// KNN query sequencer, its queue and the distance engine.
package knn_pkg;
   localparam int COORD_W = 8;
   localparam int LAT_W = 16;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic                      k5;
   } query_t;
endpackage

// File: rtl/knn_query_fifo.sv
// knn_query_fifo: registered circular query queue. A push while full is dropped.
// A pop while empty is dropped. Push and pop may happen in the same cycle.
module knn_query_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 17
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/knn_query_sequencer.sv
// knn_query_sequencer: queues KNN queries and runs them one at a time through the distance engine.
// Define KNN_TIMEOUT_EN to add a WAIT-state watchdog that forces a result after TIMEOUT_CYCLES.
module knn_query_sequencer
   import knn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      q_valid,
   output logic                      q_ready,
   input  logic signed [COORD_W-1:0] q_x,
   input  logic signed [COORD_W-1:0] q_y,
   input  logic                      q_k5,
   output logic                      eng_start,
   output logic signed [COORD_W-1:0] eng_x,
   output logic signed [COORD_W-1:0] eng_y,
   output logic                      eng_k5,
   input  logic                      eng_done,
   input  logic                      eng_class,
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic                      r_class,
   output logic                      r_k5,
   output logic [LAT_W-1:0]          r_latency,
   output logic                      r_timeout,
   output logic                      busy,
   output logic [4:0]                pending
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef KNN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   state_t state, state_nx;
   query_t q_in, head;
   logic full, empty, pop, timeout_hit, finish;
   logic [CW-1:0] count;
   logic [LAT_W-1:0] lat_cnt, lat_inc;
   assign q_in = {q_x, q_y, q_k5};
   knn_query_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(query_t))) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (q_valid),
      .pop   (pop),
      .din   (q_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign q_ready = !full;
   assign pending = 5'(count);
   assign busy = state != IDLE;
   assign eng_start = state == LAUNCH;
   assign r_valid = state == HOLD;
   assign lat_inc = &lat_cnt ? lat_cnt : lat_cnt + 1'b1;
   assign timeout_hit = TO_EN && lat_cnt == LAT_W'(TIMEOUT_CYCLES);
   assign finish = state == WAIT && (eng_done || timeout_hit);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      pop = 1'b0;
      case (state)
         IDLE: begin
            pop = !empty;
            state_nx = empty ? IDLE : LAUNCH;
         end
         LAUNCH: state_nx = WAIT;
         WAIT: state_nx = finish ? HOLD : WAIT;
         HOLD: state_nx = r_ready ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   // Operands are loaded on the pop edge and held until the next pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_x <= '0;
         eng_y <= '0;
         eng_k5 <= 1'b0;
         lat_cnt <= '0;
         r_class <= 1'b0;
         r_k5 <= 1'b0;
         r_latency <= '0;
      end else begin
         if (pop) begin
            eng_x <= head.x;
            eng_y <= head.y;
            eng_k5 <= head.k5;
         end
         if (state == LAUNCH) lat_cnt <= '0;
         else if (state == WAIT && !(&lat_cnt)) lat_cnt <= lat_cnt + 1'b1;
         if (finish) begin
            r_class <= eng_done & eng_class;
            r_k5 <= eng_k5;
            r_latency <= eng_done ? lat_inc : lat_cnt;
         end
      end
   end
`ifdef KNN_TIMEOUT_EN
   // A completion arriving on the watchdog cycle takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_timeout <= 1'b0;
      else if (finish) r_timeout <= !eng_done;
   end
`else
   assign r_timeout = 1'b0;
`endif
endmodule
